// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID->EX pipeline register of the 5-stage MIPS core. Captures
//                the decoder control bundle, register operands, sign-extended
//                immediate and destination index. Detects load-use hazards,
//                inserts a single bubble while PC/IF-ID hold, squashes the ID
//                slot on flush and counts stall cycles (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_step_en,
  input  logic               i_flush,
  input  logic               i_id_valid,
  input  logic [31:0]        i_id_instr,
  input  logic [DATA_W-1:0]  i_id_pc4,
  input  logic [DATA_W-1:0]  i_id_rs_data,
  input  logic [DATA_W-1:0]  i_id_rt_data,
  input  logic [3:0]         i_id_alu_op,
  input  logic               i_id_is_jump,
  input  logic               i_id_is_not_cond,
  input  logic               i_id_is_eq,
  input  logic               i_id_mem_write,
  input  logic               i_id_mem_read,
  input  logic               i_id_alu_src,
  input  logic               i_id_reg_dst,
  input  logic [1:0]         i_id_wbi,
  output logic               o_stall,
  output logic               o_ex_valid,
  output logic [DATA_W-1:0]  o_ex_pc4,
  output logic [DATA_W-1:0]  o_ex_rs_data,
  output logic [DATA_W-1:0]  o_ex_rt_data,
  output logic [DATA_W-1:0]  o_ex_imm,
  output logic [RADDR_W-1:0] o_ex_rt,
  output logic [RADDR_W-1:0] o_ex_rd,
  output logic [RADDR_W-1:0] o_ex_wreg,
  output logic [3:0]         o_ex_alu_op,
  output logic [1:0]         o_ex_wbi,
  output logic               o_ex_is_jump,
  output logic               o_ex_is_not_cond,
  output logic               o_ex_is_eq,
  output logic               o_ex_mem_write,
  output logic               o_ex_mem_read,
  output logic               o_ex_alu_src,
  output logic               o_ex_reg_dst,
  output logic [CNT_W-1:0]   o_stall_cnt
);

  // EX slot state
  logic               r_valid;
  logic [DATA_W-1:0]  r_pc4, r_rs_data, r_rt_data, r_imm;
  logic [RADDR_W-1:0] r_rt, r_rd, r_wreg;
  logic [3:0]         r_alu_op;
  logic [1:0]         r_wbi;
  logic               r_is_jump, r_is_not_cond, r_is_eq;
  logic               r_mem_write, r_mem_read, r_alu_src, r_reg_dst;
  logic [CNT_W-1:0]   r_stall_cnt;

  // Decoded ID fields
  logic [RADDR_W-1:0] w_id_rs, w_id_rt, w_id_rd;
  logic [DATA_W-1:0]  w_id_imm;
  logic               w_uses_rt, w_hazard, w_stall, w_load;
  logic               w_unused_opcode;

  assign w_id_rs         = RADDR_W'(i_id_instr[25:21]);
  assign w_id_rt         = RADDR_W'(i_id_instr[20:16]);
  assign w_id_rd         = RADDR_W'(i_id_instr[15:11]);
  assign w_id_imm        = {{(DATA_W-16){i_id_instr[15]}}, i_id_instr[15:0]};
  assign w_unused_opcode = ^i_id_instr[31:26];

  // Load-use detection: a load in EX whose destination an ID source needs.
  // rt only counts as a source for instructions that write rd (R-type),
  // branches and stores, all of which the decoder marks with reg_dst.
  always_comb begin
    w_uses_rt = i_id_reg_dst;
    w_hazard  = r_valid & r_mem_read & (r_rt != '0) & i_id_valid &
                ((r_rt == w_id_rs) | (w_uses_rt & (r_rt == w_id_rt)));
    w_stall   = w_hazard & ~i_flush;
    // Anything other than a clean capture of a real instruction is a bubble.
    w_load    = ~i_flush & ~w_hazard & i_id_valid;
  end

  assign o_stall = w_stall;

  // EX slot register: capture ID or load an all-zero bubble; hold when frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_pc4         <= '0;
      r_rs_data     <= '0;
      r_rt_data     <= '0;
      r_imm         <= '0;
      r_rt          <= '0;
      r_rd          <= '0;
      r_wreg        <= '0;
      r_alu_op      <= '0;
      r_wbi         <= '0;
      r_is_jump     <= 1'b0;
      r_is_not_cond <= 1'b0;
      r_is_eq       <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_alu_src     <= 1'b0;
      r_reg_dst     <= 1'b0;
    end else if (i_step_en) begin
      r_valid       <= w_load;
      r_pc4         <= w_load ? i_id_pc4     : '0;
      r_rs_data     <= w_load ? i_id_rs_data : '0;
      r_rt_data     <= w_load ? i_id_rt_data : '0;
      r_imm         <= w_load ? w_id_imm     : '0;
      r_rt          <= w_load ? w_id_rt      : '0;
      r_rd          <= w_load ? w_id_rd      : '0;
      r_wreg        <= w_load ? (i_id_reg_dst ? w_id_rd : w_id_rt) : '0;
      r_alu_op      <= w_load ? i_id_alu_op  : '0;
      r_wbi         <= w_load ? i_id_wbi     : '0;
      r_is_jump     <= w_load & i_id_is_jump;
      r_is_not_cond <= w_load & i_id_is_not_cond;
      r_is_eq       <= w_load & i_id_is_eq;
      r_mem_write   <= w_load & i_id_mem_write;
      r_mem_read    <= w_load & i_id_mem_read;
      r_alu_src     <= w_load & i_id_alu_src;
      r_reg_dst     <= w_load & i_id_reg_dst;
    end
  end

  // Saturating count of stalled stepping cycles for debug readout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (i_step_en && w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_ex_valid       = r_valid;
  assign o_ex_pc4         = r_pc4;
  assign o_ex_rs_data     = r_rs_data;
  assign o_ex_rt_data     = r_rt_data;
  assign o_ex_imm         = r_imm;
  assign o_ex_rt          = r_rt;
  assign o_ex_rd          = r_rd;
  assign o_ex_wreg        = r_wreg;
  assign o_ex_alu_op      = r_alu_op;
  assign o_ex_wbi         = r_wbi;
  assign o_ex_is_jump     = r_is_jump;
  assign o_ex_is_not_cond = r_is_not_cond;
  assign o_ex_is_eq       = r_is_eq;
  assign o_ex_mem_write   = r_mem_write;
  assign o_ex_mem_read    = r_mem_read;
  assign o_ex_alu_src     = r_alu_src;
  assign o_ex_reg_dst     = r_reg_dst;
  assign o_stall_cnt      = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage. A reference model of the
//                EX slot predicts each edge; predictions are queued when the
//                stimulus is driven and popped when the DUT output is sampled.
//                The stall counter is narrowed to 8 bits so saturation is
//                reachable in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int C_CNT_W = 8;

  // control bundle order: {is_jump, is_not_cond, is_eq, mem_write, mem_read, alu_src, reg_dst}
  localparam logic [6:0] C_CTL_ADD = 7'b0000001;
  localparam logic [6:0] C_CTL_LW  = 7'b0000110;
  localparam logic [6:0] C_CTL_SW  = 7'b0001011;

  typedef struct packed {
    logic               valid;
    logic [3:0]         alu_op;
    logic [1:0]         wbi;
    logic [6:0]         ctl;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [4:0]         wreg;
    logic [31:0]        pc4;
    logic [31:0]        rs_d;
    logic [31:0]        rt_d;
    logic [31:0]        imm;
    logic [C_CNT_W-1:0] cnt;
  } ex_t;

  logic clk = 1'b0;
  logic reset, step_en, flush, id_valid;
  logic [31:0] id_instr, id_pc4, id_rs_data, id_rt_data;
  logic [3:0]  id_alu_op;
  logic [6:0]  id_ctl;
  logic [1:0]  id_wbi;

  logic               o_stall, o_ex_valid;
  logic [31:0]        o_ex_pc4, o_ex_rs_data, o_ex_rt_data, o_ex_imm;
  logic [4:0]         o_ex_rt, o_ex_rd, o_ex_wreg;
  logic [3:0]         o_ex_alu_op;
  logic [1:0]         o_ex_wbi;
  logic               o_ex_is_jump, o_ex_is_not_cond, o_ex_is_eq;
  logic               o_ex_mem_write, o_ex_mem_read, o_ex_alu_src, o_ex_reg_dst;
  logic [C_CNT_W-1:0] o_stall_cnt;

  int  n_checks = 0;
  int  n_errors = 0;
  ex_t m;
  ex_t q[$];

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .RADDR_W(5), .CNT_W(C_CNT_W)) u_dut (
    .clk(clk), .reset(reset), .i_step_en(step_en), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_instr(id_instr), .i_id_pc4(id_pc4),
    .i_id_rs_data(id_rs_data), .i_id_rt_data(id_rt_data), .i_id_alu_op(id_alu_op),
    .i_id_is_jump(id_ctl[6]), .i_id_is_not_cond(id_ctl[5]), .i_id_is_eq(id_ctl[4]),
    .i_id_mem_write(id_ctl[3]), .i_id_mem_read(id_ctl[2]), .i_id_alu_src(id_ctl[1]),
    .i_id_reg_dst(id_ctl[0]), .i_id_wbi(id_wbi),
    .o_stall(o_stall), .o_ex_valid(o_ex_valid), .o_ex_pc4(o_ex_pc4),
    .o_ex_rs_data(o_ex_rs_data), .o_ex_rt_data(o_ex_rt_data), .o_ex_imm(o_ex_imm),
    .o_ex_rt(o_ex_rt), .o_ex_rd(o_ex_rd), .o_ex_wreg(o_ex_wreg),
    .o_ex_alu_op(o_ex_alu_op), .o_ex_wbi(o_ex_wbi), .o_ex_is_jump(o_ex_is_jump),
    .o_ex_is_not_cond(o_ex_is_not_cond), .o_ex_is_eq(o_ex_is_eq),
    .o_ex_mem_write(o_ex_mem_write), .o_ex_mem_read(o_ex_mem_read),
    .o_ex_alu_src(o_ex_alu_src), .o_ex_reg_dst(o_ex_reg_dst), .o_stall_cnt(o_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] instr, input logic [3:0] aop,
                        input logic [6:0] ctl, input logic [1:0] wbi);
    id_valid   = v;
    id_instr   = instr;
    id_alu_op  = aop;
    id_ctl     = ctl;
    id_wbi     = wbi;
    id_pc4     = $urandom;
    id_rs_data = $urandom;
    id_rt_data = $urandom;
  endtask

  task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    set_id(1'b1, {6'h00, rs, rt, rd, 5'd0, 6'h20}, 4'd2, C_CTL_ADD, 2'b11);
  endtask

  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] off);
    set_id(1'b1, {6'h23, rs, rt, off}, 4'd0, C_CTL_LW, 2'b10);
  endtask

  // One clock: check comb stall, push the predicted EX state, compare after the edge.
  task automatic tick();
    ex_t nx, want;
    logic hz, st;
    logic [4:0] rs, rt;
    #1;
    rs = id_instr[25:21];
    rt = id_instr[20:16];
    hz = m.valid && m.ctl[2] && (m.rt != 5'd0) && id_valid &&
         ((m.rt == rs) || (id_ctl[0] && (m.rt == rt)));
    st = hz && !flush;
    chk("stall", {63'd0, o_stall}, {63'd0, st});
    nx = m;
    if (reset) begin
      nx = '0;
    end else if (step_en) begin
      nx = '0;
      nx.cnt = (st && m.cnt != {C_CNT_W{1'b1}}) ? m.cnt + 1'b1 : m.cnt;
      if (!flush && !hz && id_valid) begin
        nx.valid  = 1'b1;
        nx.alu_op = id_alu_op;
        nx.wbi    = id_wbi;
        nx.ctl    = id_ctl;
        nx.rt     = rt;
        nx.rd     = id_instr[15:11];
        nx.wreg   = id_ctl[0] ? id_instr[15:11] : rt;
        nx.pc4    = id_pc4;
        nx.rs_d   = id_rs_data;
        nx.rt_d   = id_rt_data;
        nx.imm    = {{16{id_instr[15]}}, id_instr[15:0]};
      end
    end
    q.push_back(nx);
    @(posedge clk);
    #1;
    want = q.pop_front();
    m = want;
    chk("ex_valid", {63'd0, o_ex_valid}, {63'd0, want.valid});
    chk("ex_ctrl", {50'd0, o_ex_alu_op, o_ex_wbi, o_ex_is_jump, o_ex_is_not_cond, o_ex_is_eq,
                    o_ex_mem_write, o_ex_mem_read, o_ex_alu_src, o_ex_reg_dst},
        {50'd0, want.alu_op, want.wbi, want.ctl});
    chk("ex_regidx", {49'd0, o_ex_rt, o_ex_rd, o_ex_wreg}, {49'd0, want.rt, want.rd, want.wreg});
    chk("ex_pc4_imm", {o_ex_pc4, o_ex_imm}, {want.pc4, want.imm});
    chk("ex_operands", {o_ex_rs_data, o_ex_rt_data}, {want.rs_d, want.rt_d});
    chk("stall_cnt", {{(64-C_CNT_W){1'b0}}, o_stall_cnt}, {{(64-C_CNT_W){1'b0}}, want.cnt});
  endtask

  initial begin
    m = '0;
    reset = 1'b1; step_en = 1'b1; flush = 1'b0;
    set_id(1'b0, 32'd0, 4'd0, 7'd0, 2'b00);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", {63'd0, o_ex_valid}, 64'd0);
    chk("rst_cnt", {56'd0, o_stall_cnt}, 64'd0);

    // add $3,$1,$2
    set_add(5'd1, 5'd2, 5'd3);
    tick();
    chk("t1_valid", {63'd0, o_ex_valid}, 64'd1);
    chk("t1_wreg", {59'd0, o_ex_wreg}, 64'd3);
    chk("t1_aluop", {60'd0, o_ex_alu_op}, 64'd2);

    // lw $5,0($1) ; add $6,$5,$2 -> one stall
    set_lw(5'd1, 5'd5, 16'd0);
    tick();
    set_add(5'd5, 5'd2, 5'd6);
    #1 chk("t2_stall", {63'd0, o_stall}, 64'd1);
    tick();
    chk("t2_bubble", {61'd0, o_ex_valid, o_ex_wbi[1], o_ex_mem_write}, 64'd0);
    tick();
    chk("t2_stall_off", {63'd0, o_stall}, 64'd0);
    chk("t2_add_in_ex", {59'd0, o_ex_wreg}, 64'd6);
    chk("t2_cnt", {56'd0, o_stall_cnt}, 64'd1);

    // lw $5 ; sw $5,4($7) -> stall via rt
    set_lw(5'd1, 5'd5, 16'd0);
    tick();
    set_id(1'b1, {6'h2B, 5'd7, 5'd5, 16'd4}, 4'd0, C_CTL_SW, 2'b00);
    tick();
    tick();
    chk("t3_sw_imm", o_ex_imm, 64'd4);
    // lw $0 ; add $6,$0,$2 -> no stall
    set_lw(5'd1, 5'd0, 16'hFFFC);
    tick();
    chk("t3_neg_imm", {32'd0, o_ex_imm}, 64'hFFFF_FFFC);
    set_add(5'd0, 5'd2, 5'd6);
    tick();
    chk("t3_cnt", {56'd0, o_stall_cnt}, 64'd2);

    // hazard together with flush -> bubble, no stall, count unchanged
    set_lw(5'd1, 5'd5, 16'd0);
    tick();
    set_add(5'd5, 5'd2, 5'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_bubble", {63'd0, o_ex_valid}, 64'd0);
    chk("t4_cnt", {56'd0, o_stall_cnt}, 64'd2);

    // freeze during a hazard, then resolve
    set_lw(5'd1, 5'd5, 16'd0);
    tick();
    set_add(5'd5, 5'd2, 5'd6);
    step_en = 1'b0;
    repeat (3) tick();
    chk("t5_frozen_cnt", {56'd0, o_stall_cnt}, 64'd2);
    chk("t5_frozen_load", {63'd0, o_ex_mem_read}, 64'd1);
    step_en = 1'b1;
    tick();
    tick();
    chk("t5_cnt", {56'd0, o_stall_cnt}, 64'd3);

    // reset in the middle of a stall
    set_lw(5'd1, 5'd5, 16'd0);
    tick();
    set_add(5'd5, 5'd2, 5'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_cnt", {56'd0, o_stall_cnt}, 64'd0);
    tick();

    // back-to-back dependent loads: lw $5,0($5) stalls every other cycle
    set_lw(5'd5, 5'd5, 16'd0);
    repeat (2 * (1 << C_CNT_W) + 20) tick();
    chk("t6_sat", {56'd0, o_stall_cnt}, 64'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_cnt", {56'd0, o_stall_cnt}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
